// File: rtl/unit_clause_scan_ctrl.sv
// Unit-propagation front end: streams clauses from the clause RAM through a
// unit-clause finder and stops on the first unit clause or conflict.

module find_unit_clause #(
    parameter int WIDTH = 9
) (
    input  logic [3*WIDTH-1:0] clause,
    input  logic               active,
    input  logic [2:0]         mask,
    output logic               unit_clause_detected,
    output logic [WIDTH-1:0]   unit_clause
);
    always_comb begin
        unit_clause_detected = 1'b0;
        unit_clause          = '0;
        if (active) begin
            case (mask)
                3'b001: begin
                    unit_clause_detected = 1'b1;
                    unit_clause          = clause[WIDTH-1:0];
                end
                3'b010: begin
                    unit_clause_detected = 1'b1;
                    unit_clause          = clause[2*WIDTH-1:WIDTH];
                end
                3'b100: begin
                    unit_clause_detected = 1'b1;
                    unit_clause          = clause[3*WIDTH-1:2*WIDTH];
                end
                default: ;
            endcase
        end
    end
endmodule

module unit_clause_scan_ctrl #(
    parameter int WIDTH = 9,
    parameter int IDX_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [IDX_W:0]     num_clauses,
    output logic               mem_rd_en,
    output logic [IDX_W-1:0]   mem_rd_addr,
    input  logic [3*WIDTH-1:0] mem_rd_data,
    input  logic               mem_rd_active,
    input  logic [2:0]         mem_rd_mask,
    output logic               busy,
    output logic               done,
    output logic               unit_found,
    output logic               conflict,
    output logic [WIDTH-1:0]   unit_literal,
    output logic [IDX_W-1:0]   hit_index,
    output logic [IDX_W:0]     scan_count
);
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FINISH} state_t;

    localparam logic [IDX_W-1:0] ADDR_ONE = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W:0]   CNT_ONE  = {{IDX_W{1'b0}}, 1'b1};

    state_t             state, state_d;
    logic [IDX_W:0]     n_lat, n_lat_d;
    logic               pipe_v, pipe_v_d;
    logic [IDX_W-1:0]   pipe_idx, pipe_idx_d;
    logic               rd_en_d, done_d, unit_found_d, conflict_d;
    logic [IDX_W-1:0]   rd_addr_d, hit_index_d;
    logic [WIDTH-1:0]   unit_literal_d;
    logic [IDX_W:0]     scan_count_d;

    logic               fu_det;
    logic [WIDTH-1:0]   fu_lit;
    logic               hit_conf, hit_unit, last_addr;

    find_unit_clause #(.WIDTH(WIDTH)) u_find (
        .clause               (mem_rd_data),
        .active               (mem_rd_active),
        .mask                 (mem_rd_mask),
        .unit_clause_detected (fu_det),
        .unit_clause          (fu_lit)
    );

    assign busy      = (state != IDLE);
    assign hit_conf  = pipe_v && mem_rd_active && (mem_rd_mask == 3'b000);
    assign hit_unit  = pipe_v && !hit_conf && fu_det;
    assign last_addr = ({1'b0, mem_rd_addr} == (n_lat - CNT_ONE));

    always_comb begin
        state_d        = state;
        n_lat_d        = n_lat;
        rd_en_d        = mem_rd_en;
        rd_addr_d      = mem_rd_addr;
        pipe_v_d       = 1'b0;
        pipe_idx_d     = pipe_idx;
        done_d         = 1'b0;
        unit_found_d   = unit_found;
        conflict_d     = conflict;
        unit_literal_d = unit_literal;
        hit_index_d    = hit_index;
        scan_count_d   = scan_count;

        if ((state == SCAN || state == DRAIN) && !abort && pipe_v) begin
            scan_count_d = scan_count + CNT_ONE;
            if (hit_conf) begin
                conflict_d  = 1'b1;
                hit_index_d = pipe_idx;
            end else if (hit_unit) begin
                unit_found_d   = 1'b1;
                unit_literal_d = fu_lit;
                hit_index_d    = pipe_idx;
            end
        end

        case (state)
            IDLE: begin
                if (start) begin
                    n_lat_d        = num_clauses;
                    unit_found_d   = 1'b0;
                    conflict_d     = 1'b0;
                    unit_literal_d = '0;
                    hit_index_d    = '0;
                    scan_count_d   = '0;
                    rd_addr_d      = '0;
                    if (num_clauses == '0) begin
                        state_d = FINISH;
                    end else begin
                        state_d = SCAN;
                        rd_en_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (abort) begin
                    state_d = IDLE;
                    rd_en_d = 1'b0;
                end else if (hit_conf || hit_unit) begin
                    state_d = FINISH;
                    rd_en_d = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    pipe_v_d   = 1'b1;
                    pipe_idx_d = mem_rd_addr;
                    if (last_addr) begin
                        rd_en_d = 1'b0;
                        state_d = DRAIN;
                    end else begin
                        rd_addr_d = mem_rd_addr + ADDR_ONE;
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                end
            end
            FINISH: begin
                // Hits arrive here with done already raised; an empty scan
                // arrives with done low and raises it here for one cycle.
                if (done) begin
                    state_d = IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            n_lat        <= '0;
            pipe_v       <= 1'b0;
            pipe_idx     <= '0;
            mem_rd_en    <= 1'b0;
            mem_rd_addr  <= '0;
            done         <= 1'b0;
            unit_found   <= 1'b0;
            conflict     <= 1'b0;
            unit_literal <= '0;
            hit_index    <= '0;
            scan_count   <= '0;
        end else begin
            state        <= state_d;
            n_lat        <= n_lat_d;
            pipe_v       <= pipe_v_d;
            pipe_idx     <= pipe_idx_d;
            mem_rd_en    <= rd_en_d;
            mem_rd_addr  <= rd_addr_d;
            done         <= done_d;
            unit_found   <= unit_found_d;
            conflict     <= conflict_d;
            unit_literal <= unit_literal_d;
            hit_index    <= hit_index_d;
            scan_count   <= scan_count_d;
        end
    end
endmodule

// File: tb/tb_unit_clause_scan_ctrl.sv
// Randomized bench for unit_clause_scan_ctrl: a timeline model derived from the
// scan rules predicts every output each cycle; directed scenarios pin the model.

module tb_unit_clause_scan_ctrl;
    localparam int W  = 9;
    localparam int IW = 6;
    localparam int NC = 1 << IW;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [IW:0]     num_clauses = '0;
    logic            mem_rd_en;
    logic [IW-1:0]   mem_rd_addr;
    logic [3*W-1:0]  mem_rd_data = '0;
    logic            mem_rd_active = 1'b0;
    logic [2:0]      mem_rd_mask = '0;
    logic            busy, done, unit_found, conflict;
    logic [W-1:0]    unit_literal;
    logic [IW-1:0]   hit_index;
    logic [IW:0]     scan_count;

    unit_clause_scan_ctrl #(.WIDTH(W), .IDX_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .num_clauses(num_clauses), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .mem_rd_active(mem_rd_active), .mem_rd_mask(mem_rd_mask),
        .busy(busy), .done(done), .unit_found(unit_found), .conflict(conflict),
        .unit_literal(unit_literal), .hit_index(hit_index), .scan_count(scan_count)
    );

    always #5 clk = ~clk;

    logic [3*W-1:0] m_data [NC];
    logic           m_act  [NC];
    logic [2:0]     m_mask [NC];

    // Synchronous clause RAM; junk on the read port whenever no read was issued.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_data   <= m_data[mem_rd_addr];
            mem_rd_active <= m_act[mem_rd_addr];
            mem_rd_mask   <= m_mask[mem_rd_addr];
        end else begin
            mem_rd_data   <= (3*W)'({$urandom, $urandom});
            mem_rd_active <= 1'($urandom);
            mem_rd_mask   <= 3'($urandom);
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Scan outcome: hit 0 none / 1 unit / 2 conflict, at clause k. Timeline in
    // edges after the start edge: D = done edge, R = reads issued, E = evaluations.
    typedef struct {
        int n; int hit; int k; logic [W-1:0] lit; int d; int r; int e;
    } scan_t;

    typedef struct {
        logic busy; logic done; logic rd_en; logic uf; logic cf;
        int addr; int cnt; int hidx; logic [W-1:0] lit;
    } exp_t;

    scan_t m_s;
    logic  m_have = 1'b0;
    logic  m_ab   = 1'b0;
    int    m_rel  = 0;
    int    m_a    = 0;

    function automatic int imin(input int a, input int b); return (a < b) ? a : b; endfunction
    function automatic int imax(input int a, input int b); return (a > b) ? a : b; endfunction

    function automatic scan_t predict(input int n);
        scan_t s;
        s.n = n; s.hit = 0; s.k = 0; s.lit = '0;
        for (int i = 0; i < n; i++) begin
            if (m_act[i] && m_mask[i] == 3'b000) begin
                s.hit = 2; s.k = i; break;
            end
            if (m_act[i] && $countones(m_mask[i]) == 1) begin
                s.hit = 1; s.k = i;
                for (int f = 0; f < 3; f++)
                    if (m_mask[i][f]) s.lit = m_data[i][f*W +: W];
                break;
            end
        end
        if (n == 0) begin
            s.d = 1; s.r = 0; s.e = 0;
        end else if (s.hit != 0) begin
            s.d = s.k + 2; s.r = imin(n, s.k + 2); s.e = s.k + 1;
        end else begin
            s.d = n + 1; s.r = n; s.e = n;
        end
        return s;
    endfunction

    function automatic exp_t exp_now();
        exp_t x;
        int rend, ecap;
        logic shown;
        x.busy = 0; x.done = 0; x.rd_en = 0; x.uf = 0; x.cf = 0;
        x.addr = 0; x.cnt = 0; x.hidx = 0; x.lit = '0;
        if (m_have) begin
            rend    = m_ab ? imin(m_s.r, m_a) : m_s.r;
            ecap    = m_ab ? imin(m_s.e, imax(m_a - 2, 0)) : m_s.e;
            shown   = !m_ab && m_rel >= m_s.d;
            x.busy  = m_rel <= (m_ab ? m_a - 1 : m_s.d);
            x.done  = !m_ab && m_rel == m_s.d;
            x.rd_en = m_rel < rend;
            x.addr  = (rend == 0) ? 0 : imin(m_rel, rend - 1);
            x.cnt   = imin(imax(m_rel - 1, 0), ecap);
            x.uf    = shown && m_s.hit == 1;
            x.cf    = shown && m_s.hit == 2;
            x.lit   = (shown && m_s.hit == 1) ? m_s.lit : '0;
            x.hidx  = (shown && m_s.hit != 0) ? m_s.k : 0;
        end
        return x;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_have <= 1'b0;
            m_ab   <= 1'b0;
            m_rel  <= 0;
        end else if (start && !exp_now().busy) begin
            m_s    <= predict(int'(num_clauses));
            m_have <= 1'b1;
            m_ab   <= 1'b0;
            m_rel  <= 0;
        end else if (m_have) begin
            if (abort && !m_ab && m_s.n > 0 && m_rel < m_s.d) begin
                m_ab <= 1'b1;
                m_a  <= m_rel + 1;
            end
            m_rel <= m_rel + 1;
        end
    end

    always @(negedge clk) begin
        chk("busy",         32'(busy),         32'(exp_now().busy));
        chk("done",         32'(done),         32'(exp_now().done));
        chk("mem_rd_en",    32'(mem_rd_en),    32'(exp_now().rd_en));
        chk("mem_rd_addr",  32'(mem_rd_addr),  32'(exp_now().addr));
        chk("unit_found",   32'(unit_found),   32'(exp_now().uf));
        chk("conflict",     32'(conflict),     32'(exp_now().cf));
        chk("unit_literal", 32'(unit_literal), 32'(exp_now().lit));
        chk("hit_index",    32'(hit_index),    32'(exp_now().hidx));
        chk("scan_count",   32'(scan_count),   32'(exp_now().cnt));
    end

    // ---------------- stimulus ----------------
    task automatic clear_mem();
        for (int i = 0; i < NC; i++) begin
            m_data[i] = '0; m_act[i] = 1'b0; m_mask[i] = 3'b111;
        end
    endtask

    task automatic set_cl(input int i, input int l2, input int l1, input int l0,
                          input logic [2:0] m, input logic a);
        m_data[i] = {W'(l2), W'(l1), W'(l0)};
        m_mask[i] = m;
        m_act[i]  = a;
    endtask

    task automatic rand_mem();
        for (int i = 0; i < NC; i++) begin
            m_data[i] = (3*W)'({$urandom, $urandom});
            m_act[i]  = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 39))
                0:       m_mask[i] = 3'b000;
                1, 2:    m_mask[i] = 3'(1 << $urandom_range(0, 2));
                default: begin
                    m_mask[i] = 3'($urandom_range(0, 7));
                    if ($countones(m_mask[i]) < 2) m_mask[i] = 3'b111;
                end
            endcase
        end
    endtask

    // Starts a scan and follows it until busy drops; -1 disables a pulse.
    task automatic run_scan(input int n, input int again_at, input int abort_at, input logic rnd,
                            output int done_at, output int rd_cycles, output int max_addr);
        done_at = -1; rd_cycles = 0; max_addr = -1;
        num_clauses = (IW+1)'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (done) done_at = c;
            if (mem_rd_en) begin
                rd_cycles++;
                if (int'(mem_rd_addr) > max_addr) max_addr = int'(mem_rd_addr);
            end
            if (c > 0 && !busy) begin
                start = 1'b0; abort = 1'b0;
                return;
            end
            if (rnd) begin
                start = ($urandom_range(0, 7) == 0);
                abort = ($urandom_range(0, 39) == 0);
            end else begin
                start = (c == again_at);
                abort = (c == abort_at);
            end
            @(negedge clk);
        end
        start = 1'b0; abort = 1'b0;
        n_cmp++; n_bad++;
        $display("FAIL scan_timeout: busy still %0b after 400 cycles, required 0", busy);
    endtask

    int d_at, rd_c, mx_a;

    initial begin
        clear_mem();
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rd_en", 32'(mem_rd_en), 0);
        chk("rst_done", 32'(done), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Unit clause at index 2 after a satisfied-ish and an open clause.
        set_cl(0, -1, 6, 7, 3'b101, 1'b1);
        set_cl(1, -5, -6, 8, 3'b111, 1'b1);
        set_cl(2, 6, 4, 3, 3'b001, 1'b1);
        run_scan(3, -1, -1, 1'b0, d_at, rd_c, mx_a);
        chk("t1_done_at", 32'(d_at), 4);
        chk("t1_unit_found", 32'(unit_found), 1);
        chk("t1_unit_literal", 32'(unit_literal), 3);
        chk("t1_hit_index", 32'(hit_index), 2);
        chk("t1_scan_count", 32'(scan_count), 3);

        clear_mem();
        set_cl(0, 1, 2, 3, 3'b111, 1'b1);
        set_cl(1, 4, 5, 6, 3'b111, 1'b1);
        run_scan(2, -1, -1, 1'b0, d_at, rd_c, mx_a);
        chk("t2_done_at", 32'(d_at), 3);
        chk("t2_rd_cycles", 32'(rd_c), 2);
        chk("t2_unit_found", 32'(unit_found), 0);
        chk("t2_conflict", 32'(conflict), 0);
        chk("t2_scan_count", 32'(scan_count), 2);

        clear_mem();
        set_cl(0, 8, 5, 67, 3'b001, 1'b0);
        set_cl(1, -1, 46, 71, 3'b010, 1'b1);
        run_scan(2, -1, -1, 1'b0, d_at, rd_c, mx_a);
        chk("t3_unit_literal", 32'(unit_literal), 32'h02E);
        chk("t3_hit_index", 32'(hit_index), 1);

        clear_mem();
        set_cl(0, 1, 2, 3, 3'b111, 1'b1);
        set_cl(1, 1, 2, 3, 3'b000, 1'b1);
        set_cl(2, 1, 2, 3, 3'b001, 1'b1);
        set_cl(3, 1, 2, 3, 3'b111, 1'b1);
        run_scan(4, -1, -1, 1'b0, d_at, rd_c, mx_a);
        chk("t4_conflict", 32'(conflict), 1);
        chk("t4_unit_found", 32'(unit_found), 0);
        chk("t4_hit_index", 32'(hit_index), 1);
        chk("t4_scan_count", 32'(scan_count), 2);
        chk("t4_max_addr", 32'(mx_a), 2);

        clear_mem();
        for (int i = 0; i < 8; i++) set_cl(i, 1, 2, 3, 3'b111, 1'b1);
        run_scan(8, 2, 3, 1'b0, d_at, rd_c, mx_a);
        chk("t5_no_done", 32'(d_at), 32'(-1));
        chk("t5_busy", 32'(busy), 0);
        run_scan(0, -1, -1, 1'b0, d_at, rd_c, mx_a);
        chk("t5_empty_done_at", 32'(d_at), 1);
        chk("t5_empty_count", 32'(scan_count), 0);
        chk("t5_empty_unit", 32'(unit_found), 0);

        num_clauses = 7'd8;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_busy", 32'(busy), 0);
        chk("t6_async_rd_en", 32'(mem_rd_en), 0);
        chk("t6_async_count", 32'(scan_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_mem();
        set_cl(0, -1, 6, 7, 3'b101, 1'b1);
        set_cl(1, -5, -6, 8, 3'b111, 1'b1);
        set_cl(2, 6, 4, 3, 3'b001, 1'b1);
        run_scan(3, -1, -1, 1'b0, d_at, rd_c, mx_a);
        chk("t6_rescan_literal", 32'(unit_literal), 3);

        for (int t = 0; t < 40; t++) begin
            rand_mem();
            if (t % 10 == 0)      run_scan(NC, -1, -1, 1'b1, d_at, rd_c, mx_a);
            else if (t % 10 == 1) run_scan(0, -1, -1, 1'b1, d_at, rd_c, mx_a);
            else                  run_scan($urandom_range(1, NC), -1, -1, 1'b1, d_at, rd_c, mx_a);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Full store with no hits: all 2**IDX_W indices scanned once.
        clear_mem();
        for (int i = 0; i < NC; i++) m_act[i] = 1'b1;
        run_scan(NC, -1, -1, 1'b0, d_at, rd_c, mx_a);
        chk("full_done_at", 32'(d_at), 32'(NC + 1));
        chk("full_rd_cycles", 32'(rd_c), 32'(NC));
        chk("full_scan_count", 32'(scan_count), 32'(NC));

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/unit_clause_scan_ctrl.md
Name: unit_clause_scan_ctrl

Overview:
Sequencer that walks a clause store one clause per cycle and feeds each clause through an internal FIND_UNIT_CLAUSE instance. It stops on the first unit clause, or on the first conflict (an active clause with no unresolved literals), and reports the literal and clause index. It sits between the DPLL top-level FSM and the clause RAM and serves as the unit-propagation front end.

Parameters:
WIDTH, 9, bit width of one signed literal (two's complement; negative value means negated variable)
IDX_W, 6, clause index width; store holds up to 2**IDX_W clauses

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin scan; sampled only in IDLE
abort  input  1  synchronous cancel; returns to IDLE with no done pulse
num_clauses  input  IDX_W+1  number of clauses to scan, 0..2**IDX_W; latched on start
mem_rd_en  output  1  clause RAM read strobe
mem_rd_addr  output  IDX_W  clause RAM read address
mem_rd_data  input  3*WIDTH  packed clause {lit2,lit1,lit0}, valid 1 cycle after rd_en
mem_rd_active  input  1  clause-active flag, same timing as mem_rd_data
mem_rd_mask  input  3  unresolved-literal mask (bit i = field i), same timing
busy  output  1  high while not IDLE
done  output  1  one-cycle pulse at scan completion
unit_found  output  1  a unit clause was found (held until next start)
conflict  output  1  an active clause with mask 000 was found (held)
unit_literal  output  WIDTH  literal of the unit clause, else 0
hit_index  output  IDX_W  index of the unit or conflict clause, else 0
scan_count  output  IDX_W+1  number of clauses evaluated in the last scan

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0, including mem_rd_en, mem_rd_addr and the result registers. Takes effect immediately mid-scan; the in-flight read is discarded.
- States: IDLE, SCAN, DRAIN, FINISH. All outputs are registered.
- IDLE: at edge E0 with start=1:
  - Latch num_clauses and clear unit_found, conflict, unit_literal, hit_index and scan_count.
  - If num_clauses=0, go to FINISH. Otherwise go to SCAN with mem_rd_addr=0 and mem_rd_en=1.
- SCAN: issue one address per cycle (0,1,2,...).
  - Track the returning clause with a 1-cycle valid pipe bit and its index.
  - After issuing address num_clauses-1, drop mem_rd_en and go to DRAIN.
- Evaluation: at each edge where the pipe bit is valid, mem_rd_* drives the FIND_UNIT_CLAUSE instance combinationally, then:
  - If active=1 and mask=000: set conflict=1 and hit_index=idx, then go to FINISH.
  - Else if unit_clause_detected: set unit_found=1, unit_literal=unit_clause and hit_index=idx, then go to FINISH.
  - An inactive clause never hits.
  - scan_count increments for every evaluated clause, including the hit clause.
- On a hit: mem_rd_en drops on the same edge. The already-issued read for idx+1 is ignored. Lowest index always wins.
- DRAIN: evaluate the last clause, then go to FINISH.
- FINISH: assert done for exactly one cycle and return to IDLE.
- Latency:
  - Clause k is evaluated at edge E(k+2).
  - A hit at k raises done in the cycle after E(k+2).
  - No hit: done in the cycle after E(N+1). N=0: done in the cycle after E1.
- Idle/abort/start rules:
  - start while busy is ignored.
  - abort in SCAN or DRAIN: go to IDLE next edge, mem_rd_en=0, no done; results keep partial values.
  - abort in IDLE or FINISH has no effect.
  - abort and start together in IDLE: start wins.
- The address counter never wraps. num_clauses=2**IDX_W scans indices 0..2**IDX_W-1 exactly once.

Test Plan:
1. N=3; clauses {-1,6,7} m=101 act=1, {-5,-6,8} m=111 act=1, {6,4,3} m=001 act=1 -> unit_found=1, unit_literal=3, hit_index=2, scan_count=3, done in the cycle after E4.
2. N=2; both m=111 act=1 -> done in the cycle after E3, unit_found=0, conflict=0, scan_count=2, mem_rd_en high for exactly 2 cycles.
3. N=2; idx0 {8,5,67} m=001 act=0, idx1 {-1,46,71} m=010 act=1 -> inactive clause skipped; unit_literal=46 (9'h02E), hit_index=1.
4. N=4; idx0 m=111, idx1 m=000 act=1, idx2 m=001 -> conflict=1, unit_found=0, hit_index=1, scan_count=2, no read issued after address 2.
5. N=8; start pulsed again at E2 (ignored); abort at E3 -> IDLE at E4, no done, busy=0. Then N=0 start -> done one cycle later with all results 0.
6. N=8; rst_n low mid-SCAN -> busy, mem_rd_en, done and all results go to 0 asynchronously; after release a new start scans from address 0.
